mpmc11_rd_collector: RTL and testbench
======================================

# mpmc11_rd_collector

Read-return side of the mpmc11 strip engine. The controller issues strip reads at 32-byte strides from a base address. This block receives the returning read-data beats from the DRAM user interface, buffers them, and forwards them to the requesting channel. Each forwarded strip carries its reconstructed strip address, strip index and a last-strip marker. It sits between the DRAM app read-data port and the per-channel read-response mux.

## Interface
- DEPTH, 16: strip-buffer entries; power of two, minimum 4.
- DW, 256: data bits per beat. One beat is one 32-byte strip.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that opens a burst. Accepted only in RDC_IDLE.
- addr_base  in  32  burst base address. Bits [4:0] are ignored.
- num_strips  in  6  strips in the burst, minus 1 (0 = 1 strip, 63 = 64 strips).
- chan  in  4  requesting channel id.
- rd_data_valid  in  1  DRAM read beat present. Cannot be backpressured.
- rd_data  in  DW  DRAM read beat.
- out_valid  out  1  strip available to channel.
- out_ready  in  1  channel accepts strip.
- out_data  out  DW  strip data.
- out_addr  out  32  strip address = {addr_base[31:5],5'h0} + 32·out_strip.
- out_strip  out  6  strip index within burst.
- out_last  out  1  out_strip == num_strips.
- out_chan  out  4  latched chan.
- busy  out  1  state != RDC_IDLE.
- done  out  1  one-cycle pulse on burst completion.
- space  out  $clog2(DEPTH)+1  free buffer entries. The controller throttles read issue on this count.
- err  out  1  sticky: beat dropped (overflow, stray or excess beat).

## Operation
- State type mpmc11_rdc_state_t: RDC_IDLE, RDC_COLLECT, RDC_DRAIN.
- RDC_IDLE, on start:
  - latch base (addr_base[31:5],5'h0), num_strips and chan;
  - clear rx_cnt and tx_cnt;
  - go to RDC_COLLECT.
- start outside RDC_IDLE is ignored; the latched values do not change.
- RDC_COLLECT, on each rd_data_valid:
  - if the buffer is not full, or is full with a pop in the same cycle: push the beat and increment rx_cnt;
  - otherwise drop the beat and set err.
- Transition RDC_COLLECT→RDC_DRAIN when the push of beat index num_strips is accepted, or when that beat is dropped. The burst always terminates.
- RDC_DRAIN:
  - rd_data_valid drops the beat and sets err (excess beat);
  - when the pop with out_last completes, go to RDC_IDLE and pulse done.
- A pop (out_valid & out_ready) increments tx_cnt. The pop can occur in RDC_COLLECT or RDC_DRAIN.
- out_strip = tx_cnt, out_addr = base + {tx_cnt,5'h0}. Addition is 32-bit and wraps modulo 2^32.
- Dropped beats also advance rx_cnt, so indices stay aligned with DRAM order. A dropped strip is never presented. In that case done fires after the last surviving strip pops, and out_last is only ever asserted for the strip whose index equals num_strips.
  - If the final strip itself was dropped, done fires after the last surviving strip pops, or in the cycle after entering RDC_DRAIN if the buffer is already empty.
- rd_data_valid in RDC_IDLE drops the beat and sets err.
- err clears only on rst.

## Timing
- Reset values:
  - state RDC_IDLE, buffer empty, space = DEPTH;
  - out_valid 0, done 0, busy 0, err 0;
  - out_data, out_addr, out_strip and out_chan read 0.
- Latency from rd_data_valid to out_valid is 1 cycle (registered buffer read, no bypass).
- out_valid, out_data, out_addr, out_strip, out_last and out_chan stay stable until out_ready is high on a rising edge.
- space updates on the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- done is registered and rises in the cycle after the final pop. A new start is accepted in that same cycle.
- rst asserted mid-burst discards all buffered strips next edge; no done pulse.

## Structure
- mpmc11_pkg gains mpmc11_rdc_state_t and the constant MPMC11_STRIP_BYTES = 32.
- Sub-module mpmc11_strip_fifo:
  - synchronous FIFO holding DW data bits only;
  - pointers one bit wider than the index, for full/empty;
  - outputs full, empty and count.
- Address, strip index and last-strip marker are derived from tx_cnt, not stored.

## Test plan
- Single strip: start, addr_base=0x0000_1234, num_strips=0, chan=3; one beat D0 → out_valid next cycle with out_addr=0x0000_1220, out_strip=0, out_last=1, out_chan=3; done one cycle after the pop.
- Four back-to-back beats, out_ready=1: addr_base=0x100 → out_addr 0x100, 0x120, 0x140, 0x160 on consecutive cycles, out_last only on 0x160, err=0.
- Backpressure overflow: DEPTH=16, num_strips=19, out_ready=0 → space reaches 0 after 16 beats, beats 16–19 dropped, err=1. Release out_ready → strips 0–15 delivered; done fires after strip 15 pops with out_last never asserted.
- Full with simultaneous pop: buffer full, beat arrives in a cycle with out_ready=1 → beat accepted, space stays 0, err stays 0.
- Address wrap: addr_base=0xFFFF_FFC0, num_strips=3 → out_addr 0xFFFF_FFC0, 0xFFFF_FFE0, 0x0000_0000, 0x0000_0020.
- Stray and reset: rd_data_valid in RDC_IDLE → err=1 with no out_valid. rst mid-burst → next cycle busy=0, space=DEPTH, out_valid=0, no done.

Source files
------------

// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 strip engine.
// Holds the read-collector state encoding and the strip address helper.
package mpmc11_pkg;

    localparam int MPMC11_STRIP_BYTES = 32;

    typedef enum logic [1:0] {
        RDC_IDLE    = 2'd0,
        RDC_COLLECT = 2'd1,
        RDC_DRAIN   = 2'd2
    } mpmc11_rdc_state_t;

    // Strip address: 32-byte aligned base plus index strides, wrapping modulo 2^32.
    function automatic logic [31:0] mpmc11_strip_addr(input logic [26:0] base_hi,
                                                      input logic [5:0]  idx);
        return {base_hi, 5'h00} + (32'(idx) * 32'(MPMC11_STRIP_BYTES));
    endfunction

endpackage

// File: rtl/mpmc11_strip_fifo.sv
// Synchronous strip buffer: data-only FIFO with extended pointers for full/empty.
// The head entry is read combinationally from registered storage and reads 0 when empty.
module mpmc11_strip_fifo #(
    parameter int DEPTH = 16,
    parameter int DW    = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_wdata,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;

    // Storage write; contents need no reset since the head is masked while empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            if (i_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/mpmc11_rd_collector.sv
// Read-return collector: buffers DRAM read beats of one strip burst and forwards them
// to the requesting channel with reconstructed strip address, index and last marker.
module mpmc11_rd_collector
    import mpmc11_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              addr_base,
    input  logic [5:0]               num_strips,
    input  logic [3:0]               chan,
    input  logic                     rd_data_valid,
    input  logic [DW-1:0]            rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [31:0]              out_addr,
    output logic [5:0]               out_strip,
    output logic                     out_last,
    output logic [3:0]               out_chan,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   space,
    output logic                     err
);
    localparam int AW = $clog2(DEPTH);

    mpmc11_rdc_state_t r_state;
    logic [26:0]       r_base_hi;
    logic [5:0]        r_num;
    logic [5:0]        r_rx_cnt;
    logic [5:0]        r_tx_cnt;
    logic [3:0]        r_chan;
    logic              r_done;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_count;
    logic [DW-1:0]     w_rdata;
    logic              w_pop;
    logic              w_push;
    logic              w_final_pop;

    // A full buffer still accepts a beat when the head leaves in the same cycle.
    always_comb begin
        w_pop       = !w_empty && out_ready;
        w_push      = (r_state == RDC_COLLECT) && rd_data_valid && (!w_full || w_pop);
        w_final_pop = w_pop && (w_count == (AW+1)'(1));
    end

    mpmc11_strip_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (rd_data),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Burst control; dropped beats still advance rx_cnt so the burst always terminates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= RDC_IDLE;
            r_base_hi <= 27'd0;
            r_num     <= 6'd0;
            r_rx_cnt  <= 6'd0;
            r_tx_cnt  <= 6'd0;
            r_chan    <= 4'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_pop) r_tx_cnt <= r_tx_cnt + 6'd1;
            case (r_state)
                RDC_IDLE: begin
                    if (rd_data_valid) r_err <= 1'b1;
                    if (start) begin
                        r_base_hi <= addr_base[31:5];
                        r_num     <= num_strips;
                        r_chan    <= chan;
                        r_rx_cnt  <= 6'd0;
                        r_tx_cnt  <= 6'd0;
                        r_state   <= RDC_COLLECT;
                    end
                end
                RDC_COLLECT: begin
                    if (rd_data_valid) begin
                        r_rx_cnt <= r_rx_cnt + 6'd1;
                        if (!w_push) r_err <= 1'b1;
                        if (r_rx_cnt == r_num) r_state <= RDC_DRAIN;
                    end
                end
                RDC_DRAIN: begin
                    if (rd_data_valid) r_err <= 1'b1;
                    // No pushes here, so the burst ends when the buffer runs dry.
                    if (w_empty || w_final_pop) begin
                        r_state <= RDC_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= RDC_IDLE;
            endcase
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_rdata;
    assign out_addr  = mpmc11_strip_addr(r_base_hi, r_tx_cnt);
    assign out_strip = r_tx_cnt;
    assign out_last  = out_valid && (r_tx_cnt == r_num);
    assign out_chan  = r_chan;
    assign busy      = (r_state != RDC_IDLE);
    assign done      = r_done;
    assign space     = (AW+1)'(DEPTH) - w_count;
    assign err       = r_err;

endmodule

// File: tb/tb_mpmc11_rd_collector.sv
// Directed bench for mpmc11_rd_collector: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_mpmc11_rd_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  addr_base;
    logic [5:0]   num_strips;
    logic [3:0]   chan;
    logic         rd_data_valid;
    logic [255:0] rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [31:0]  out_addr;
    logic [5:0]   out_strip;
    logic         out_last;
    logic [3:0]   out_chan;
    logic         busy;
    logic         done;
    logic [4:0]   space;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    mpmc11_rd_collector #(.DEPTH(16), .DW(256)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .addr_base     (addr_base),
        .num_strips    (num_strips),
        .chan          (chan),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .out_strip     (out_strip),
        .out_last      (out_last),
        .out_chan      (out_chan),
        .busy          (busy),
        .done          (done),
        .space         (space),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk(input int k);
        return {8{32'hC0DE_0000 + 32'(k)}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] wrap_addr [4];

    initial begin
        wrap_addr[0] = 32'hFFFF_FFC0;
        wrap_addr[1] = 32'hFFFF_FFE0;
        wrap_addr[2] = 32'h0000_0000;
        wrap_addr[3] = 32'h0000_0020;

        rst = 1'b1; start = 1'b0; addr_base = 32'h0; num_strips = 6'd0; chan = 4'd0;
        rd_data_valid = 1'b0; rd_data = '0; out_ready = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_space", space, 16);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_strip", out_strip, 0);
        chk("rst_chan", out_chan, 0);

        // Single strip
        start = 1'b1; addr_base = 32'h0000_1234; num_strips = 6'd0; chan = 4'd3;
        step();
        start = 1'b0;
        chk("s1_busy", busy, 1);
        chk("s1_valid_pre", out_valid, 0);
        rd_data_valid = 1'b1; rd_data = mk(0); out_ready = 1'b1;
        step();
        rd_data_valid = 1'b0;
        chk("s1_valid", out_valid, 1);
        chk("s1_addr", out_addr, 32'h0000_1220);
        chk("s1_strip", out_strip, 0);
        chk("s1_last", out_last, 1);
        chk("s1_chan", out_chan, 3);
        chk("s1_data", out_data, mk(0));
        chk("s1_space", space, 15);
        chk("s1_done_early", done, 0);
        step();
        chk("s1_done", done, 1);
        chk("s1_busy_end", busy, 0);
        chk("s1_valid_end", out_valid, 0);
        chk("s1_space_end", space, 16);
        step();
        chk("s1_done_pulse", done, 0);

        // Four back-to-back beats, always ready
        start = 1'b1; addr_base = 32'h0000_0100; num_strips = 6'd3; chan = 4'd5;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_data_valid = 1'b1; rd_data = mk(i);
            step();
            chk("b2b_valid", out_valid, 1);
            chk("b2b_addr", out_addr, 32'h100 + 32'(i) * 32'd32);
            chk("b2b_strip", out_strip, i);
            chk("b2b_last", out_last, (i == 3) ? 1 : 0);
            chk("b2b_data", out_data, mk(i));
            chk("b2b_chan", out_chan, 5);
        end
        rd_data_valid = 1'b0;
        step();
        chk("b2b_done", done, 1);
        chk("b2b_err", err, 0);

        // Overflow under backpressure: 20 beats into 16 entries
        out_ready = 1'b0;
        start = 1'b1; addr_base = 32'h0000_2000; num_strips = 6'd19; chan = 4'd7;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd_data_valid = 1'b1; rd_data = mk(i);
            if (i == 1) begin
                start = 1'b1; chan = 4'd9; addr_base = 32'h0000_8000;
            end
            step();
            start = 1'b0;
            if (i == 15) begin
                chk("ovf_space0", space, 0);
                chk("ovf_err_none", err, 0);
            end
        end
        rd_data_valid = 1'b0;
        chk("ovf_err", err, 1);
        chk("ovf_chan_kept", out_chan, 7);
        chk("ovf_busy", busy, 1);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("ovf_strip", out_strip, j);
            chk("ovf_addr", out_addr, 32'h2000 + 32'(j) * 32'd32);
            chk("ovf_data", out_data, mk(j));
            chk("ovf_last", out_last, 0);
            chk("ovf_done_early", done, 0);
            step();
        end
        chk("ovf_done", done, 1);
        chk("ovf_busy_end", busy, 0);
        chk("ovf_valid_end", out_valid, 0);

        // Full buffer with simultaneous pop
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("fp_err_clr", err, 0);
        out_ready = 1'b0;
        start = 1'b1; addr_base = 32'h0; num_strips = 6'd17; chan = 4'd1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_data_valid = 1'b1; rd_data = mk(i);
            step();
        end
        chk("fp_full", space, 0);
        out_ready = 1'b1;
        rd_data_valid = 1'b1; rd_data = mk(16);
        step();
        chk("fp_space", space, 0);
        chk("fp_err", err, 0);
        chk("fp_strip", out_strip, 1);
        chk("fp_data", out_data, mk(1));
        rd_data_valid = 1'b1; rd_data = mk(17);
        step();
        rd_data_valid = 1'b0;
        chk("fp_err2", err, 0);
        for (int j = 2; j < 18; j++) begin
            chk("fp_dstrip", out_strip, j);
            chk("fp_ddata", out_data, mk(j));
            chk("fp_dlast", out_last, (j == 17) ? 1 : 0);
            step();
        end
        chk("fp_done", done, 1);
        chk("fp_err_end", err, 0);

        // Address wrap
        start = 1'b1; addr_base = 32'hFFFF_FFC0; num_strips = 6'd3; chan = 4'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_data_valid = 1'b1; rd_data = mk(40 + i);
            step();
            chk("wrap_addr", out_addr, wrap_addr[i]);
            chk("wrap_last", out_last, (i == 3) ? 1 : 0);
        end
        rd_data_valid = 1'b0;
        step();
        chk("wrap_done", done, 1);

        // Stray beat in idle
        step();
        rd_data_valid = 1'b1; rd_data = mk(99);
        step();
        rd_data_valid = 1'b0;
        chk("stray_err", err, 1);
        chk("stray_valid", out_valid, 0);
        chk("stray_space", space, 16);
        chk("stray_busy", busy, 0);

        // Reset mid-burst
        out_ready = 1'b0;
        start = 1'b1; addr_base = 32'h4000; num_strips = 6'd7; chan = 4'd6;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_data_valid = 1'b1; rd_data = mk(i);
            step();
        end
        rd_data_valid = 1'b0;
        chk("mid_space", space, 13);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_space_rst", space, 16);
        chk("mid_valid", out_valid, 0);
        chk("mid_done", done, 0);
        chk("mid_err", err, 0);
        step();
        chk("mid_done2", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
